// File: rtl/log_event_pkg.sv
// Shared types and default widths for the log event arbiter and its output FIFO.
package log_event_pkg;

  typedef enum logic [1:0] {
    SEV_INFO       = 2'd0,
    SEV_INFO_GREEN = 2'd1,
    SEV_WARNING    = 2'd2,
    SEV_ERROR      = 2'd3
  } sev_e;

  localparam int NUM_SRC_DEF    = 4;
  localparam int MSG_W_DEF      = 16;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int CNT_W_DEF      = 16;
  localparam int TS_W_DEF       = 32;
  localparam int SRC_W_DEF      = $clog2(NUM_SRC_DEF);

  // Layout at default widths; the top builds the same layout from its own parameters.
  typedef struct packed {
    sev_e                 sev;
    logic [SRC_W_DEF-1:0] src;
    logic [MSG_W_DEF-1:0] msg;
    logic [TS_W_DEF-1:0]  ts;
  } log_entry_t;

  function automatic logic is_info(input sev_e s);
    return (s == SEV_INFO) || (s == SEV_INFO_GREEN);
  endfunction

endpackage

// File: rtl/log_event_fifo.sv
// Synchronous FIFO of log entries with occupancy output; when empty the head
// shows the last popped entry so out_* never go X.
module log_event_fifo
  import log_event_pkg::*;
#(
  parameter int  DEPTH   = FIFO_DEPTH_DEF,
  parameter type entry_t = log_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 dout,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);

  entry_t        mem [DEPTH];
  entry_t        last;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (level != '0);
  assign full    = (level == (AW + 1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign dout    = valid ? mem[rd_ptr] : last;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      last   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        last   <= mem[rd_ptr];
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/log_event_arbiter.sv
// Round-robin arbiter sharing one timestamped log sink among NUM_SRC requesters.
// Define LOG_ERR_PRIORITY_EN to let ERROR requests win over all non-error requests.
module log_event_arbiter
  import log_event_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int MSG_W      = MSG_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TS_W       = TS_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [2*NUM_SRC-1:0]          src_sev,
  input  logic [MSG_W*NUM_SRC-1:0]      src_msg,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:0]                    out_sev,
  output logic [$clog2(NUM_SRC)-1:0]    out_src,
  output logic [MSG_W-1:0]              out_msg,
  output logic [TS_W-1:0]               out_ts,
  input  logic                          clr_cnt,
  output logic [CNT_W-1:0]              info_cnt,
  output logic [CNT_W-1:0]              warning_cnt,
  output logic [CNT_W-1:0]              error_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);

  typedef struct packed {
    sev_e             sev;
    logic [SRC_W-1:0] src;
    logic [MSG_W-1:0] msg;
    logic [TS_W-1:0]  ts;
  } entry_t;

  function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return SRC_W'(s);
  endfunction

  sev_e             sev_arr [NUM_SRC];
  logic [MSG_W-1:0] msg_arr [NUM_SRC];
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] winner;
  logic [TS_W-1:0]  ts;
  logic             found;
  logic             full;
  logic             accept;
  entry_t           push_entry;
  entry_t           head;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign sev_arr[g] = sev_e'(src_sev[2*g +: 2]);
    assign msg_arr[g] = src_msg[MSG_W*g +: MSG_W];
  end

  // Scan from rr_ptr upward; with priority enabled an error-only pass runs first.
  always_comb begin
    found  = 1'b0;
    winner = '0;
`ifdef LOG_ERR_PRIORITY_EN
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && src_valid[rr_idx(rr_ptr, i)] && sev_arr[rr_idx(rr_ptr, i)] == SEV_ERROR) begin
        found  = 1'b1;
        winner = rr_idx(rr_ptr, i);
      end
    end
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && src_valid[rr_idx(rr_ptr, i)]) begin
        found  = 1'b1;
        winner = rr_idx(rr_ptr, i);
      end
    end
  end

  // Reset gates the grant directly so src_ready falls without waiting for a clock.
  assign src_ready = (found && !full && !rst) ? (NUM_SRC'(1) << winner) : '0;
  assign accept    = |(src_valid & src_ready);

  assign push_entry = '{sev: sev_arr[winner], src: winner, msg: msg_arr[winner], ts: ts};

  log_event_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (push_entry),
    .pop   (out_ready),
    .dout  (head),
    .valid (out_valid),
    .full  (full),
    .level (fifo_level)
  );

  assign out_sev = head.sev;
  assign out_src = head.src;
  assign out_msg = head.msg;
  assign out_ts  = head.ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts     <= '0;
      rr_ptr <= '0;
    end else begin
      ts <= ts + TS_ONE;
      if (accept) rr_ptr <= rr_idx(winner, 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      info_cnt    <= '0;
      warning_cnt <= '0;
      error_cnt   <= '0;
    end else if (clr_cnt) begin
      info_cnt    <= '0;
      warning_cnt <= '0;
      error_cnt   <= '0;
    end else if (accept) begin
      if (is_info(sev_arr[winner])) begin
        if (info_cnt != '1) info_cnt <= info_cnt + CNT_ONE;
      end else if (sev_arr[winner] == SEV_WARNING) begin
        if (warning_cnt != '1) warning_cnt <= warning_cnt + CNT_ONE;
      end else begin
        if (error_cnt != '1) error_cnt <= error_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_log_event_arbiter.sv
// Bench for log_event_arbiter: directed steps plus a cycle model whose expected
// entries queue up on accept and are compared as the FIFO head drains.
module tb_log_event_arbiter;

  localparam int NUM_SRC    = 4;
  localparam int MSG_W      = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 4;
  localparam int TS_W       = 32;
  localparam int EW         = 2 + 2 + MSG_W + TS_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_SRC-1:0]   src_valid;
  logic [NUM_SRC-1:0]   src_ready;
  logic [2*NUM_SRC-1:0] src_sev;
  logic [MSG_W*NUM_SRC-1:0] src_msg;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_sev;
  logic [1:0]           out_src;
  logic [MSG_W-1:0]     out_msg;
  logic [TS_W-1:0]      out_ts;
  logic                 clr_cnt;
  logic [CNT_W-1:0]     info_cnt;
  logic [CNT_W-1:0]     warning_cnt;
  logic [CNT_W-1:0]     error_cnt;
  logic [3:0]           fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];

  log_event_arbiter #(
    .NUM_SRC(NUM_SRC), .MSG_W(MSG_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .src_sev(src_sev), .src_msg(src_msg), .out_valid(out_valid), .out_ready(out_ready),
    .out_sev(out_sev), .out_src(out_src), .out_msg(out_msg), .out_ts(out_ts),
    .clr_cnt(clr_cnt), .info_cnt(info_cnt), .warning_cnt(warning_cnt),
    .error_cnt(error_cnt), .fifo_level(fifo_level)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: rotate from ptr, optional error-first pass.
  function automatic int model_pick(input logic [3:0] v, input logic [7:0] sev, input int ptr);
    logic [7:0] t;
`ifdef LOG_ERR_PRIORITY_EN
    for (int k = 0; k < NUM_SRC; k++) begin
      int s;
      s = (ptr + k) % NUM_SRC;
      t = sev >> (2 * s);
      if (v[s] && t[1:0] == 2'd3) return s;
    end
`endif
    for (int k = 0; k < NUM_SRC; k++) begin
      int s;
      s = (ptr + k) % NUM_SRC;
      if (v[s]) return s;
    end
    return -1;
  endfunction

  // scoreboard / model state
  int               m_level;
  int               m_ptr;
  logic [TS_W-1:0]  m_ts;
  logic [CNT_W-1:0] m_info, m_warn, m_err;
  logic [EW-1:0]    m_last;

  always @(negedge clk) begin
    int            w;
    logic          acc;
    logic          pop;
    logic [3:0]    er;
    logic [7:0]    st;
    logic [63:0]   mt;
    logic [EW-1:0] head;
    if (rst) begin
      m_level = 0; m_ptr = 0; m_ts = '0;
      m_info = '0; m_warn = '0; m_err = '0;
      m_last = '0;
      exp_q.delete();
    end else begin
      w   = model_pick(src_valid, src_sev, m_ptr);
      acc = (w >= 0) && (m_level < FIFO_DEPTH);
      er  = '0;
      if (acc) er[w] = 1'b1;
      check("src_ready", src_ready, er);
      check("fifo_level", fifo_level, m_level);
      check("out_valid", out_valid, m_level != 0);
      check("info_cnt", info_cnt, m_info);
      check("warning_cnt", warning_cnt, m_warn);
      check("error_cnt", error_cnt, m_err);
      head = (m_level != 0 && exp_q.size() > 0) ? exp_q[0] : m_last;
      check("out_entry", {out_sev, out_src, out_msg, out_ts}, head);
      pop = (m_level != 0) && out_ready;
      if (pop) m_last = exp_q.pop_front();
      if (acc) begin
        st = src_sev >> (2 * w);
        mt = src_msg >> (MSG_W * w);
        exp_q.push_back({st[1:0], 2'(w), mt[MSG_W-1:0], m_ts});
        if (st[1:0] <= 2'd1) begin
          if (m_info != '1) m_info = m_info + 1'b1;
        end else if (st[1:0] == 2'd2) begin
          if (m_warn != '1) m_warn = m_warn + 1'b1;
        end else begin
          if (m_err != '1) m_err = m_err + 1'b1;
        end
      end
      if (clr_cnt) begin
        m_info = '0; m_warn = '0; m_err = '0;
      end
      m_level = m_level + (acc ? 1 : 0) - (pop ? 1 : 0);
      if (acc) m_ptr = (w + 1) % NUM_SRC;
      m_ts = m_ts + 1'b1;
    end
  end

  // driver helpers
  task automatic drive_src(input int s, input logic [1:0] sev, input logic [15:0] msg);
    src_valid[s]           = 1'b1;
    src_sev[2*s +: 2]      = sev;
    src_msg[MSG_W*s +: MSG_W] = msg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; src_valid = '0; src_sev = '0; src_msg = '0;
    out_ready = 1'b1; clr_cnt = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_src_ready", src_ready, 4'b0);
    check("rst_level", fifo_level, 4'd0);
    check("rst_cnt", {info_cnt, warning_cnt, error_cnt}, 12'h0);
    check("rst_out", {out_sev, out_src, out_msg, out_ts}, 52'h0);
    step();
    rst = 1'b0;

    // single source accepted at ts=10
    repeat (10) step();
    drive_src(0, 2'd0, 16'h1234);
    @(negedge clk);
    check("single_grant", src_ready, 4'b0001);
    step();
    src_valid = '0;
    @(negedge clk);
    check("single_valid", out_valid, 1'b1);
    check("single_msg", out_msg, 16'h1234);
    check("single_src", out_src, 2'd0);
    check("single_ts", out_ts, 32'd10);
    check("single_info", info_cnt, 4'd1);

    // round robin, pointer now at 1
    step();
    drive_src(0, 2'd0, 16'hA000);
    drive_src(1, 2'd1, 16'hA001);
    drive_src(2, 2'd2, 16'hA002);
    drive_src(3, 2'd3, 16'hA003);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_order", src_ready, 4'b0001 << ((1 + k) % 4));
    end
    step();
    src_valid = '0;

    // full: only src1, no sink
    repeat (3) step();
    out_ready = 1'b0;
    drive_src(1, 2'd0, 16'h5000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("full_level", fifo_level, 4'd8);
    check("full_ready", src_ready, 4'b0);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("full_pop_no_grant", src_ready, 4'b0);
    @(negedge clk);
    check("full_resume", src_ready, 4'b0010);
    step();
    src_valid = '0;
    repeat (10) step();

    // counter saturation, then clear racing a warning accept
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    drive_src(3, 2'd3, 16'hE000);
    repeat (17) @(posedge clk);
    #1;
    src_valid = '0;
    @(negedge clk);
    check("err_saturate", error_cnt, 4'hF);
    step();
    drive_src(2, 2'd2, 16'hB000);
    clr_cnt = 1'b1;
    @(negedge clk);
    check("clr_warn_grant", src_ready, 4'b0100);
    step();
    src_valid = '0;
    clr_cnt   = 1'b0;
    @(negedge clk);
    check("clr_warn_cnt", warning_cnt, 4'd0);
    check("clr_all_cnt", {info_cnt, error_cnt}, 8'h0);

    // async reset with 5 queued entries
    repeat (2) step();
    out_ready = 1'b0;
    drive_src(0, 2'd0, 16'h7777);
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_level", fifo_level, 4'd5);
    check("pre_rst_info", info_cnt, 4'd5);
    #1;
    rst = 1'b1;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_level", fifo_level, 4'd0);
    check("async_cnt", {info_cnt, warning_cnt, error_cnt}, 12'h0);
    check("async_ready", src_ready, 4'b0);
    step();
    rst = 1'b0;
    src_valid = '0;
    out_ready = 1'b1;

    // error priority with pointer at 0
    drive_src(0, 2'd0, 16'hC000);
    drive_src(2, 2'd3, 16'hC002);
    @(negedge clk);
`ifdef LOG_ERR_PRIORITY_EN
    check("prio_first", src_ready, 4'b0100);
`else
    check("prio_first", src_ready, 4'b0001);
`endif
    @(negedge clk);
`ifdef LOG_ERR_PRIORITY_EN
    check("prio_second", src_ready, 4'b0001);
`else
    check("prio_second", src_ready, 4'b0100);
`endif
    step();
    src_valid = '0;
    repeat (4) step();
    @(negedge clk);
    check("drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
